// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the connector pins, deserializes 11-bit
// device-to-host frames and folds E0/F0 prefixes into flag bits on key_event.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] key_event,
    output logic        frame_err
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W = 4;
    localparam int unsigned SHIFT_W = 10;

    localparam logic [7:0]       CODE_EXT = 8'hE0;
    localparam logic [7:0]       CODE_BRK = 8'hF0;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(10);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic               clk_s1;
    logic               clk_s2;
    logic               clk_d;
    logic               data_s1;
    logic               data_s2;
    logic               fall_tick;

    logic [BIT_W-1:0]   bit_cnt;
    logic [SHIFT_W-1:0] shift;
    logic [CNT_W-1:0]   idle_cnt;
    logic               ext;
    logic               brk;

    logic [10:0]        frame_c;
    logic [7:0]         code_c;
    logic               frame_ok_c;
    logic               start_ignored_c;

    // Pin synchronizers; all ones at reset so no false falling edge follows.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall_tick = ~clk_s2 & clk_d;

    // Complete frame as seen on the stop-bit tick: stop bit is still on the pin.
    always_comb begin
        frame_c         = {data_s2, shift};
        code_c          = frame_c[8:1];
        frame_ok_c      = ~frame_c[0] & frame_c[10] & (^frame_c[9:1]);
        start_ignored_c = (bit_cnt == '0) & data_s2;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt   <= '0;
            shift     <= '0;
            idle_cnt  <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            key_event <= '0;
            frame_err <= 1'b0;
        end else begin
            key_event[10] <= 1'b0;
            frame_err     <= 1'b0;

            if (fall_tick) begin
                idle_cnt <= '0;
                if (!start_ignored_c) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (!frame_ok_c) begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end else if (code_c == CODE_EXT) begin
                            ext <= 1'b1;
                        end else if (code_c == CODE_BRK) begin
                            brk <= 1'b1;
                        end else begin
                            key_event <= {1'b1, ext, brk, code_c};
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end
                    end else begin
                        shift   <= {data_s2, shift[SHIFT_W-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
            end else if (bit_cnt != '0) begin
                // A stalled partial frame is dropped silently, prefixes included.
                if (idle_cnt == IDLE_MAX) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus randomized
// frames compared against a byte-level model of the prefix/event rules.
module tb_ps2_key_decoder;
    localparam int unsigned TO  = 200;
    localparam int unsigned LOW = 10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] key_event;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed activity, accumulated on the falling clk edge.
    int          ev_cnt   = 0;
    int          err_cnt  = 0;
    int          both_cnt = 0;
    int          wide_cnt = 0;
    logic [10:0] last_ev  = '0;
    logic        prev_stb = 1'b0;
    logic        prev_err = 1'b0;

    // Reference model state.
    logic        m_ext  = 1'b0;
    logic        m_brk  = 1'b0;
    logic [9:0]  m_hold = '0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event[10]) begin
            ev_cnt  = ev_cnt + 1;
            last_ev = key_event;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (key_event[10] && frame_err) both_cnt = both_cnt + 1;
        if ((key_event[10] && prev_stb) || (frame_err && prev_err)) wide_cnt = wide_cnt + 1;
        prev_stb = key_event[10];
        prev_err = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad);
        logic par;
        par = (~^code) ^ bad;
        return {1'b1, par, code, 1'b0};
    endfunction

    task automatic send_bit(input logic b, input int hi);
        @(negedge clk);
        ps2_data = b;
        repeat (hi) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (LOW) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int from, input int to, input int hi);
        for (int i = from; i <= to; i++) send_bit(f[i], hi);
    endtask

    // Byte-level rules: prefixes set flags, bad frames clear them, others emit.
    task automatic model_frame(input logic [7:0] code, input logic bad,
                               output int exp_ev, output int exp_err, output logic [10:0] exp_val);
        exp_ev  = 0;
        exp_err = 0;
        exp_val = '0;
        if (bad) begin
            exp_err = 1;
            m_ext   = 1'b0;
            m_brk   = 1'b0;
        end else if (code == 8'hE0) begin
            m_ext = 1'b1;
        end else if (code == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_ev  = 1;
            exp_val = {1'b1, m_ext, m_brk, code};
            m_hold  = exp_val[9:0];
            m_ext   = 1'b0;
            m_brk   = 1'b0;
        end
    endtask

    task automatic do_frame(input logic [7:0] code, input logic bad, input int hi, input int gap_bit);
        int          e0;
        int          r0;
        int          exp_ev;
        int          exp_err;
        logic [10:0] exp_val;
        logic [10:0] f;
        e0 = ev_cnt;
        r0 = err_cnt;
        model_frame(code, bad, exp_ev, exp_err, exp_val);
        f = mk_frame(code, bad);
        for (int i = 0; i <= 10; i++) send_bit(f[i], (i == gap_bit) ? int'(TO) - 20 : hi);
        repeat (4) @(negedge clk);
        #1;
        check("ev_count", ev_cnt - e0, exp_ev);
        check("err_count", err_cnt - r0, exp_err);
        if (exp_ev != 0) check("event", 32'(last_ev), 32'(exp_val));
        check("hold", 32'(key_event[9:0]), 32'(m_hold));
        check("strobe_low", 32'(key_event[10]), 0);
    endtask

    task automatic quiet_window(input string tag, input int e0, input int r0);
        check({tag, "_ev"}, ev_cnt - e0, 0);
        check({tag, "_err"}, err_cnt - r0, 0);
    endtask

    initial begin
        int e0;
        int r0;
        logic [10:0] f;

        rstn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_event", 32'(key_event), 0);
        check("rst_err", 32'(frame_err), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Make / break of W
        do_frame(8'h1D, 1'b0, 12, -1);
        check("w_make", 32'(last_ev), 32'h41D);
        do_frame(8'hF0, 1'b0, 12, -1);
        do_frame(8'h1D, 1'b0, 12, -1);
        check("w_break", 32'(last_ev), 32'h51D);

        // Extended keys, then flags must be cleared
        do_frame(8'hE0, 1'b0, 12, -1);
        do_frame(8'h75, 1'b0, 12, -1);
        check("up_make", 32'(last_ev), 32'h675);
        do_frame(8'hE0, 1'b0, 12, -1);
        do_frame(8'hF0, 1'b0, 12, -1);
        do_frame(8'h75, 1'b0, 12, -1);
        check("up_break", 32'(last_ev), 32'h775);
        do_frame(8'hF0, 1'b0, 12, -1);
        do_frame(8'hE0, 1'b0, 12, -1);
        do_frame(8'hF0, 1'b0, 12, -1);
        do_frame(8'h75, 1'b0, 12, -1);
        check("swapped_prefix", 32'(last_ev), 32'h775);
        do_frame(8'h23, 1'b0, 12, -1);
        check("plain_after", 32'(last_ev), 32'h423);

        // Parity error clears the pending break
        do_frame(8'hF0, 1'b0, 12, -1);
        do_frame(8'h1C, 1'b1, 12, -1);
        do_frame(8'h1C, 1'b0, 12, -1);
        check("after_parity", 32'(last_ev), 32'h41C);

        // Idle-line glitch with data high is ignored
        e0 = ev_cnt;
        r0 = err_cnt;
        send_bit(1'b1, 12);
        repeat (6) @(negedge clk);
        #1;
        quiet_window("glitch", e0, r0);
        do_frame(8'h23, 1'b0, 12, -1);
        check("after_glitch", 32'(last_ev), 32'h423);

        // Partial frame times out and drops the pending prefix
        do_frame(8'hF0, 1'b0, 12, -1);
        e0 = ev_cnt;
        r0 = err_cnt;
        f  = mk_frame(8'h77, 1'b0);
        send_bits(f, 0, 4, 12);
        repeat (TO + 50) @(negedge clk);
        #1;
        quiet_window("timeout", e0, r0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        do_frame(8'h34, 1'b0, 12, -1);
        check("after_timeout", 32'(last_ev), 32'h434);

        // A long gap just under the timeout still completes the frame
        do_frame(8'h2B, 1'b0, 12, 6);
        check("long_gap", 32'(last_ev), 32'h42B);

        // Reset mid-frame after bit 6 of 0x1B
        do_frame(8'hE0, 1'b0, 12, -1);
        e0 = ev_cnt;
        r0 = err_cnt;
        f  = mk_frame(8'h1B, 1'b0);
        send_bits(f, 0, 6, 12);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_event", 32'(key_event), 0);
        check("midrst_err", 32'(frame_err), 0);
        rstn   = 1'b1;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_hold = '0;
        send_bits(f, 7, 10, 12);
        repeat (TO + 50) @(negedge clk);
        #1;
        quiet_window("midrst", e0, r0);
        do_frame(8'h1B, 1'b0, 12, -1);
        check("after_midrst", 32'(last_ev), 32'h41B);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            int          sel;
            logic [7:0]  code;
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      code = 8'hE0;
            else if (sel < 4) code = 8'hF0;
            else              code = 8'($urandom_range(0, 255));
            do_frame(code, ($urandom_range(0, 9) == 0), int'($urandom_range(6, 30)), -1);
        end

        check("strobe_err_overlap", both_cnt, 0);
        check("pulse_width", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard line (clock and data from the connector) and produces the 11-bit `key_event` bus that the cursor/selection logic consumes. It synchronizes the asynchronous PS/2 pins, deserializes 11-bit device-to-host frames, checks framing and parity, and folds the E0/F0 prefix bytes into flag bits. Each completed key code is issued as a single-cycle event, so downstream blocks act exactly once per make or break.

## Interface
- `TIMEOUT_CYCLES`, default 100000: number of clk cycles without a PS/2 falling edge, mid-frame, after which the partial frame is discarded (1 ms at 100 MHz).
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; synchronous and active-low.
- `ps2_clk`  in  1  PS/2 clock pin; asynchronous; idle high.
- `ps2_data`  in  1  PS/2 data pin; asynchronous; idle high.
- `key_event`  out  11  event bus:
  - [10] new-event strobe, one cycle.
  - [9] extended (E0 seen).
  - [8] break (F0 seen).
  - [7:0] scan code.
- `frame_err`  out  1  one-cycle pulse on a parity, start-bit or stop-bit error.

## Operation
- Synchronizers:
  - Two-FF synchronizers on `ps2_clk` and `ps2_data`, followed by one delay register on the synchronized clock.
  - All three registers reset to 1, so there is no spurious edge after reset.
  - `fall_tick` = synchronized clock is 0 and the delayed copy is 1.
- Frame: on each `fall_tick`, sample synchronized data into bit position `bit_cnt` (0..10), then increment `bit_cnt`.
  - Bit 0 is the start bit and must be 0.
  - Bits 1-8 are data, LSB first.
  - Bit 9 is odd parity: bits 1-9 must contain an odd number of ones.
  - Bit 10 is the stop bit and must be 1.
- On the 11th `fall_tick`, `bit_cnt` returns to 0 and the frame is evaluated:
  - Any check fails: pulse `frame_err`, no event, clear the `ext` and `brk` flags.
  - Byte = 0xE0: set `ext`, no event.
  - Byte = 0xF0: set `brk`, no event.
  - Any other byte (including E1, AA, FA): emit `key_event` = {1, ext, brk, byte}, then clear `ext` and `brk`.
- Timeout:
  - An idle counter resets on every `fall_tick` and counts only while `bit_cnt` != 0.
  - When it reaches `TIMEOUT_CYCLES`, `bit_cnt` returns to 0 and `ext`/`brk` clear. No `frame_err` is pulsed and no event is issued.
- Holding: `key_event[9:0]` hold their last emitted value until the next event. `key_event[10]` is 0 on every cycle except the emit cycle.
- Data on the line while `bit_cnt` = 0 and the start bit reads 1: the edge is ignored, `bit_cnt` stays 0, and no error is flagged (resynchronizes to glitches).
- Prefix ordering: E0 then F0 and F0 then E0 both yield ext=1, brk=1. Repeated prefixes are idempotent.

## Timing
- Reset values:
  - `key_event` = 0, `frame_err` = 0.
  - `bit_cnt` = 0, `ext` = 0, `brk` = 0, idle counter = 0.
  - Synchronizer and delay registers = 1.
- Reset is sampled on clk. It takes priority over everything; asserting it mid-frame discards the frame, and no event follows.
- `fall_tick` occurs 3 clk cycles after a pin falling edge (±1 for metastability resolution).
- `key_event[10]` and `frame_err` assert in the cycle after the `fall_tick` that samples the stop bit; latency is 1 cycle.
- `key_event[10]` and `frame_err` never assert in the same cycle. Neither asserts for more than 1 cycle.
- Minimum PS/2 bit period is ≥ 4 clk cycles (real devices: 60-100 µs). Edges closer than that are undefined.
- Timeout and `fall_tick` in the same cycle: `fall_tick` wins and the counter resets.
- Counter width: ceil(log2(`TIMEOUT_CYCLES`+1)); saturation is never reached in idle because the counter is held at 0 while `bit_cnt` = 0.

## Test plan
- Make of W: frame 0x1D (parity bit 1) → exactly one cycle with `key_event` = 11'h41D, then [10]=0 with [9:0] holding 10'h01D; `frame_err` stays 0.
- Break of W: frames F0, 1D → a single event 11'h51D, and no event after the F0 frame.
- Extended up-arrow: E0, 75 → 11'h675. Extended release E0, F0, 75 → 11'h775. Next plain frame 0x23 → 11'h423 (flags cleared).
- Parity error: send F0, then 0x1C with the parity bit inverted → `frame_err` pulses once, no event; a following 0x1C yields 11'h41C (brk cleared).
- Timeout: 5 bits, then an idle gap > `TIMEOUT_CYCLES` clk cycles, then a full 0x34 frame → 11'h434, no `frame_err`. A gap of `TIMEOUT_CYCLES`-10 between bits → the frame completes normally.
- Reset mid-frame: assert `rstn`=0 for 1 cycle after bit 6 of 0x1B, finish the remaining bits, then send 0x1B → no event and no `frame_err` from the truncated frame (its leftover bits ignored or timed out); second frame yields 11'h41B; all outputs read 0 during reset.
